// File: rtl/fm_mod_nco.sv
// fm_mod_nco: FM modulator; scaled message plus carrier offset is integrated into a phase accumulator driving a quarter-wave sin/cos LUT.
// Ports: sclk/rst (async, active high); msg_in/msg_valid/msg_ready sample handshake on divider ticks;
//   kf deviation gain; fc_word carrier increment; I_out/Q_out/iq_valid/phase_out I/Q result; underrun_cnt missed samples.
// Define FM_MOD_DITHER_EN to add LFSR dither to the LUT address path (accumulator and phase_out stay undithered).
module fm_mod_nco #(
  parameter int N = 18,
  parameter int PHASE_W = 24,
  parameter int LUT_AW = 10,
  parameter int SHIFT = 10,
  parameter logic [23:0] FRE_STEP = 24'd524288
) (
  input  logic               sclk,
  input  logic               rst,
  input  logic [N-1:0]       msg_in,
  input  logic               msg_valid,
  output logic               msg_ready,
  input  logic [15:0]        kf,
  input  logic [PHASE_W-1:0] fc_word,
  output logic [N-1:0]       I_out,
  output logic [N-1:0]       Q_out,
  output logic               iq_valid,
  output logic [PHASE_W-1:0] phase_out,
  output logic [7:0]         underrun_cnt
);
  localparam int A = 2**(N-1)-1;
  localparam int DW = PHASE_W-2-LUT_AW;
  // Elaboration-time sine table built from a Taylor series so no math library is needed.
  function automatic logic [N-2:0] lut_val(int k);
    real x, t, s;
    x = 3.14159265358979323846 / 2.0 * real'(k) / real'(1 << LUT_AW);
    t = x;
    s = x;
    for (int i = 1; i < 14; i++) begin
      t = -t * x * x / real'((2*i)*(2*i+1));
      s = s + t;
    end
    return (N-1)'($rtoi(real'(A) * s + 0.5));
  endfunction
  logic [N-2:0] lut [0:2**LUT_AW];
  for (genvar k = 0; k <= 2**LUT_AW; k++) begin : g_lut
    assign lut[k] = lut_val(k);
  end
  logic [23:0] div_acc;
  logic tick, v1, v2, v3, v4;
  logic [N-1:0] held, cur;
  logic signed [N+16:0] prod;
  logic [PHASE_W-1:0] dphi, phase, ph3, ph4;
  logic [LUT_AW+1:0] top;
  logic [LUT_AW:0] sa, ca, sa_n, ca_n;
  logic s3, c3, s4, c4;
  logic [N-2:0] sv, cv;
`ifdef FM_MOD_DITHER_EN
  logic [15:0] lfsr;
  // Dither only contributes a carry into the address bits; the compare is that carry without a wide adder.
  assign top = phase[PHASE_W-1 -: LUT_AW+2] + (LUT_AW+2)'(lfsr[DW-1:0] > ~phase[DW-1:0]);
`else
  assign top = phase[PHASE_W-1 -: LUT_AW+2];
`endif
  assign msg_ready = tick;
  assign cur = msg_valid ? msg_in : held;
  assign prod = $signed(cur) * $signed({1'b0, kf});
  // Odd quadrants read the table mirrored; cosine is the sine path one quadrant ahead.
  assign sa_n = top[LUT_AW] ? (LUT_AW+1)'(2**LUT_AW) - {1'b0, top[LUT_AW-1:0]} : {1'b0, top[LUT_AW-1:0]};
  assign ca_n = top[LUT_AW] ? {1'b0, top[LUT_AW-1:0]} : (LUT_AW+1)'(2**LUT_AW) - {1'b0, top[LUT_AW-1:0]};
  always_ff @(posedge sclk or posedge rst)
    if (rst) begin
      {tick, div_acc} <= '0;
      {v1, v2, v3, v4, iq_valid} <= '0;
      held <= '0;
      underrun_cnt <= '0;
      dphi <= '0;
      phase <= '0;
      ph3 <= '0;
      ph4 <= '0;
      sa <= '0;
      ca <= '0;
      {s3, c3, s4, c4} <= '0;
      sv <= '0;
      cv <= '0;
      I_out <= '0;
      Q_out <= '0;
      phase_out <= '0;
`ifdef FM_MOD_DITHER_EN
      lfsr <= 16'hACE1;
`endif
    end else begin
      {tick, div_acc} <= {1'b0, div_acc} + {1'b0, FRE_STEP};
      {v1, v2, v3, v4, iq_valid} <= {tick, v1, v2, v3, v4};
      if (tick) begin
        held <= cur;
        dphi <= fc_word + PHASE_W'(prod >>> SHIFT);
        if (!msg_valid && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
`ifdef FM_MOD_DITHER_EN
        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
`endif
      end
      if (v1) phase <= phase + dphi;
      if (v2) begin
        ph3 <= phase;
        sa <= sa_n;
        ca <= ca_n;
        s3 <= top[LUT_AW+1];
        c3 <= top[LUT_AW+1] ^ top[LUT_AW];
      end
      if (v3) begin
        ph4 <= ph3;
        sv <= lut[sa];
        cv <= lut[ca];
        s4 <= s3;
        c4 <= c3;
      end
      if (v4) begin
        phase_out <= ph4;
        Q_out <= s4 ? -{1'b0, sv} : {1'b0, sv};
        I_out <= c4 ? -{1'b0, cv} : {1'b0, cv};
      end
    end
endmodule

// File: tb/tb_fm_mod_nco.sv
// tb_fm_mod_nco: directed and random stimulus for fm_mod_nco, checked against a queue of model predictions.
module tb_fm_mod_nco;
  localparam int A = 131071;
`ifdef FM_MOD_DITHER_EN
  localparam int TOL = 202;
`else
  localparam int TOL = 0;
`endif
  logic sclk = 1'b0, rst = 1'b1;
  logic [17:0] msg_in = '0, I_out, Q_out;
  logic msg_valid = 1'b0, msg_ready, iq_valid;
  logic [15:0] kf = '0;
  logic [23:0] fc_word = '0, phase_out;
  logic [7:0] underrun_cnt;
  typedef struct { int i; int q; logic [23:0] ph; int cyc; } exp_t;
  exp_t sb[$];
  exp_t e;
  int total = 0, bad = 0, cyc = 0;
  logic [23:0] mphase = '0;
  logic [17:0] mheld = '0, mcur;
  longint p;
  fm_mod_nco dut (
    .sclk(sclk), .rst(rst), .msg_in(msg_in), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .kf(kf), .fc_word(fc_word), .I_out(I_out), .Q_out(Q_out), .iq_valid(iq_valid),
    .phase_out(phase_out), .underrun_cnt(underrun_cnt)
  );
  always #5 sclk = ~sclk;
  function automatic int iq_of(logic [23:0] ph, bit cosine);
    real ang, v;
    int m;
    ang = 2.0 * 3.14159265358979323846 * real'(ph[23:12]) / 4096.0;
    v = cosine ? $cos(ang) : $sin(ang);
    m = $rtoi((v < 0.0 ? -v : v) * real'(A) + 0.5);
    return v < 0.0 ? -m : m;
  endfunction
  task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask
  task automatic chk_iq(string tag, logic signed [31:0] got, logic signed [31:0] want);
    total++;
    assert (TOL == 0 ? got === want : (got - want <= TOL && want - got <= TOL)) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask
  always @(negedge sclk) begin
    if (rst) begin
      sb.delete();
      mphase = '0;
      mheld = '0;
      cyc = 0;
    end else begin
      cyc++;
      if (iq_valid) begin
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("FAIL strobe_unexpected got iq_valid=1 want 0 (nothing pending)");
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("latency_cycle", cyc, e.cyc);
          chk("phase_out", phase_out, e.ph);
          chk_iq("I_out", $signed(I_out), e.i);
          chk_iq("Q_out", $signed(Q_out), e.q);
        end
      end
      if (msg_ready) begin
        mcur = msg_valid ? msg_in : mheld;
        mheld = mcur;
        p = longint'($signed(mcur)) * longint'(kf);
        mphase = mphase + fc_word + 24'(p >>> 10);
        sb.push_back('{iq_of(mphase, 1'b1), iq_of(mphase, 1'b0), mphase, cyc + 5});
      end
    end
  end
  task automatic next_tick();
    int n = 0;
    do begin
      @(negedge sclk);
      n++;
    end while (msg_ready !== 1'b1 && n < 100);
    chk("tick_seen", msg_ready, 1);
    @(posedge sclk);
    #1;
  endtask
  task automatic do_reset();
    @(posedge sclk);
    #1 rst = 1'b1;
    #1;
    chk("rst_I", I_out, 0);
    chk("rst_Q", Q_out, 0);
    chk("rst_iq_valid", iq_valid, 0);
    chk("rst_msg_ready", msg_ready, 0);
    chk("rst_phase", phase_out, 0);
    chk("rst_underrun", underrun_cnt, 0);
    repeat (3) @(posedge sclk);
    #1 rst = 1'b0;
  endtask
  initial begin
    do_reset();
    msg_valid = 1'b1;
    repeat (3) next_tick();
    repeat (6) @(posedge sclk);
    #1;
    chk("t2_I", $signed(I_out), A);
    chk_iq("t2_Q", $signed(Q_out), 0);
    chk("t2_phase", phase_out, 0);
    fc_word = 24'h400000;
    do_reset();
    repeat (2) next_tick();
    repeat (6) @(posedge sclk);
    #1;
    chk("t3_I_half", $signed(I_out), -A);
    chk("t3_phase_half", phase_out, 24'h800000);
    repeat (3) next_tick();
    @(posedge sclk);
    do_reset();
    fc_word = '0;
    kf = 16'd1024;
    msg_in = 18'd1000;
    repeat (3) next_tick();
    msg_in = -18'sd1000;
    repeat (4) next_tick();
    repeat (6) @(posedge sclk);
    #1;
    chk("t4_phase_wrap", phase_out, 24'hFFFC18);
    for (int k = 0; k < 8; k++) begin
      fc_word = 24'($urandom);
      kf = 16'($urandom_range(0, 65535));
      msg_in = 18'($urandom);
      next_tick();
    end
    do_reset();
    fc_word = '0;
    kf = 16'd1024;
    msg_in = 18'd500;
    msg_valid = 1'b1;
    next_tick();
    msg_valid = 1'b0;
    msg_in = 18'h1ABCD;
    repeat (3) next_tick();
    chk("t5_underrun3", underrun_cnt, 3);
    repeat (6) @(posedge sclk);
    #1;
    chk("t5_phase_held", phase_out, 24'd2000);
    repeat (252) next_tick();
    chk("t5_underrun255", underrun_cnt, 255);
    repeat (48) next_tick();
    chk("t5_underrun_sat", underrun_cnt, 255);
    repeat (20) begin
      if (sb.size() != 0) @(posedge sclk);
    end
    chk("drain_pending", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
